xbar_router: RTL and testbench



---
 rtl/xbar_pkg.sv | 13 +
 rtl/xbar_router_scan_divider.sv | 33 +++
 rtl/xbar_router.sv | 92 +++++++++
 tb/tb_xbar_router.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared constants and lane-slicing helper for the crossbar router and its scan divider.
package xbar_pkg;

  localparam int NCH_DEF      = 4;
  localparam int W_DEF        = 4;
  localparam int SCAN_DIV_SIM = 4;

  // Low bit index of lane idx inside a flat NCH*W bus.
  function automatic int lane_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/xbar_router_scan_divider.sv
// Scan step divider: free-runs 0..SCAN_DIV-1 while enabled, pulses tick at terminal count.
module scan_divider
  import xbar_pkg::*;
#(
  parameter  int SCAN_DIV = SCAN_DIV_SIM,
  localparam int DW       = $clog2(SCAN_DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic restart,
  output logic tick
);

  logic [DW-1:0] cnt;
  logic          at_tc;

  assign at_tc = (cnt == DW'(SCAN_DIV - 1));
  // clr and restart both win over the terminal count, so that cycle never ticks.
  assign tick  = en & at_tc & ~clr & ~restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || clr || restart || at_tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end

endmodule

// File: rtl/xbar_router.sv
// Registered NCH x NCH lane crossbar: one source lane routed to one destination lane,
// route latched on a rising edge of load, optional auto-scan of the source lane.
module xbar_router
  import xbar_pkg::*;
#(
  parameter  int NCH      = NCH_DEF,
  parameter  int W        = W_DEF,
  parameter  int SCAN_DIV = 50000000,
  parameter  int HOLD     = 0,
  localparam int SW       = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*W-1:0]  din,
  input  logic [SW-1:0]     src_sel,
  input  logic [SW-1:0]     dst_sel,
  input  logic              load,
  input  logic              scan_en,
  input  logic              clr,
  output logic [NCH*W-1:0]  dout,
  output logic [SW-1:0]     cur_src,
  output logic [SW-1:0]     cur_dst,
  output logic              scan_tick
);

  localparam logic [SW:0] NCH_LIM = (SW+1)'(NCH);

  logic             load_q;
  logic             load_edge;
  logic             src_ok;
  logic             dst_ok;
  logic [W-1:0]     din_lane [NCH];
  logic [W-1:0]     sel_lane;
  logic [NCH*W-1:0] dout_nxt;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign din_lane[i] = din[lane_lo(i, W) +: W];
  end

  assign load_edge = load & ~load_q;
  // Out-of-range selects only exist for non-power-of-2 NCH; they leave that field alone.
  assign src_ok    = ({1'b0, src_sel} < NCH_LIM);
  assign dst_ok    = ({1'b0, dst_sel} < NCH_LIM);
  assign sel_lane  = din_lane[cur_src];

  scan_divider #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_divider (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (scan_en),
    .clr     (clr),
    .restart (load_edge),
    .tick    (scan_tick)
  );

  always_comb begin
    dout_nxt = (HOLD != 0) ? dout : '0;
    for (int i = 0; i < NCH; i++) begin
      if (cur_dst == SW'(i)) begin
        dout_nxt[lane_lo(i, W) +: W] = sel_lane;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (clr) begin
      dout <= '0;
    end else begin
      dout <= dout_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q  <= 1'b0;
      cur_src <= '0;
      cur_dst <= '0;
    end else begin
      load_q <= load;
      if (load_edge) begin
        if (src_ok) cur_src <= src_sel;
        if (dst_ok) cur_dst <= dst_sel;
      end else if (scan_tick) begin
        cur_src <= (cur_src == SW'(NCH - 1)) ? '0 : cur_src + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_xbar_router.sv
// Bench for xbar_router: three instances (4x4 zero-policy, 4x4 hold-policy, 3x8 zero-policy)
// checked every cycle against a lane-array model, plus directed literal expectations.
module tb_xbar_router;

  localparam int SD = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] din_ab;
  logic [23:0] din_c;
  logic [1:0]  src_sel;
  logic [1:0]  dst_sel;
  logic        load;
  logic        scan_en;
  logic        clr;

  logic [15:0] dout_a, dout_b;
  logic [23:0] dout_c;
  logic [1:0]  cur_src_a, cur_dst_a, cur_src_b, cur_dst_b, cur_src_c, cur_dst_c;
  logic        tick_a, tick_b, tick_c;

  xbar_router #(.NCH(4), .W(4), .SCAN_DIV(SD), .HOLD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_ab), .src_sel(src_sel), .dst_sel(dst_sel),
    .load(load), .scan_en(scan_en), .clr(clr), .dout(dout_a),
    .cur_src(cur_src_a), .cur_dst(cur_dst_a), .scan_tick(tick_a));

  xbar_router #(.NCH(4), .W(4), .SCAN_DIV(SD), .HOLD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_ab), .src_sel(src_sel), .dst_sel(dst_sel),
    .load(load), .scan_en(scan_en), .clr(clr), .dout(dout_b),
    .cur_src(cur_src_b), .cur_dst(cur_dst_b), .scan_tick(tick_b));

  xbar_router #(.NCH(3), .W(8), .SCAN_DIV(SD), .HOLD(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .din(din_c), .src_sel(src_sel), .dst_sel(dst_sel),
    .load(load), .scan_en(scan_en), .clr(clr), .dout(dout_c),
    .cur_src(cur_src_c), .cur_dst(cur_dst_c), .scan_tick(tick_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [3:0]  cs;
    logic [3:0]  cd;
    logic [3:0]  dv;
    logic        lq;
    logic [31:0] lanes;   // four 8-bit lane values
  } mstate_t;

  mstate_t m [3];
  int nch_of [3] = '{4, 4, 3};
  int w_of   [3] = '{4, 4, 8};
  int hold_of[3] = '{0, 1, 0};

  function automatic int in_lane(input int k, input int idx);
    if (k < 2) return int'((din_ab >> (idx * 4)) & 16'hF);
    return int'((din_c >> (idx * 8)) & 24'hFF);
  endfunction

  function automatic bit m_tick(input int k);
    bit le;
    le = load && !m[k].lq;
    return scan_en && !clr && !le && (int'(m[k].dv) == SD - 1);
  endfunction

  function automatic logic [31:0] m_dout(input int k);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < nch_of[k]; j++)
      r = r | (32'(m[k].lanes[j*8 +: 8]) << (j * w_of[k]));
    return r;
  endfunction

  function automatic mstate_t step(input int k);
    mstate_t s, n;
    int nch, v;
    bit le;
    s   = m[k];
    n   = s;
    nch = nch_of[k];
    le  = load && !s.lq;
    for (int j = 0; j < 4; j++) begin
      if (clr || j >= nch)             v = 0;
      else if (j == int'(s.cd))        v = in_lane(k, int'(s.cs));
      else if (hold_of[k] != 0)        v = int'(s.lanes[j*8 +: 8]);
      else                             v = 0;
      n.lanes[j*8 +: 8] = 8'(v);
    end
    if (le) begin
      if (int'(src_sel) < nch) n.cs = 4'(src_sel);
      if (int'(dst_sel) < nch) n.cd = 4'(dst_sel);
    end else if (m_tick(k)) begin
      n.cs = 4'((int'(s.cs) + 1) % nch);
    end
    n.dv = (!scan_en || clr || le) ? 4'd0 : 4'((int'(s.dv) + 1) % SD);
    n.lq = load;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) m[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) m[k] <= step(k);
    end
  end

  logic [31:0] a_dout [3];
  logic [1:0]  a_cs   [3];
  logic [1:0]  a_cd   [3];
  logic        a_tk   [3];
  assign a_dout[0] = {16'b0, dout_a};
  assign a_dout[1] = {16'b0, dout_b};
  assign a_dout[2] = {8'b0, dout_c};
  assign a_cs[0] = cur_src_a; assign a_cs[1] = cur_src_b; assign a_cs[2] = cur_src_c;
  assign a_cd[0] = cur_dst_a; assign a_cd[1] = cur_dst_b; assign a_cd[2] = cur_dst_c;
  assign a_tk[0] = tick_a;    assign a_tk[1] = tick_b;    assign a_tk[2] = tick_c;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model dout[%0d]", k), a_dout[k], m_dout(k));
        chk($sformatf("model cur_src[%0d]", k), 32'(a_cs[k]), 32'(m[k].cs));
        chk($sformatf("model cur_dst[%0d]", k), 32'(a_cd[k]), 32'(m[k].cd));
        chk($sformatf("model scan_tick[%0d]", k), 32'(a_tk[k]), 32'(m_tick(k)));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [3:0] exp_lane [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
  logic [1:0] exp_csc  [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

  initial begin
    int n;
    rst_n = 1'b1; load = 1'b0; scan_en = 1'b0; clr = 1'b0;
    src_sel = '0; dst_sel = '0;
    din_ab = 16'hFFFF; din_c = 24'hFFFFFF;
    #3 rst_n = 1'b0;
    #20;
    @(posedge clk); #2 rst_n = 1'b1; chk_on = 1'b1;
    cyc(1);
    chk("post-reset dout_a", 32'(dout_a), 32'h000F);
    chk("post-reset dout_b", 32'(dout_b), 32'h000F);
    chk("post-reset dout_c", 32'(dout_c), 32'h0000FF);

    // Asynchronous reset asserted mid-cycle
    cyc(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset dout_a", 32'(dout_a), 32'h0);
    chk("async reset cur_src_a", 32'(cur_src_a), 32'h0);
    chk("async reset cur_dst_a", 32'(cur_dst_a), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    cyc(1);
    chk("reset release dout_a", 32'(dout_a), 32'h000F);

    // Manual route 2->3, load held high afterwards
    din_ab = 16'h4321; din_c = 24'h332211;
    src_sel = 2'd2; dst_sel = 2'd3; load = 1'b1;
    cyc(1);
    chk("route cur_src_a", 32'(cur_src_a), 32'd2);
    chk("route cur_dst_a", 32'(cur_dst_a), 32'd3);
    cyc(1);
    chk("route dout_a", 32'(dout_a), 32'h3000);
    chk("invalid dst cur_dst_c", 32'(cur_dst_c), 32'd0);
    chk("route dout_c", 32'(dout_c), 32'h000033);
    src_sel = 2'd1; dst_sel = 2'd0;
    cyc(4);
    chk("load held cur_src_a", 32'(cur_src_a), 32'd2);
    chk("load held cur_dst_a", 32'(cur_dst_a), 32'd3);
    chk("load held dout_a", 32'(dout_a), 32'h3000);
    load = 1'b0;
    cyc(1);

    // clr coincident with load edge, then HOLD behaviour
    src_sel = 2'd1; dst_sel = 2'd0; load = 1'b1; clr = 1'b1;
    cyc(1);
    chk("clr+load dout_a", 32'(dout_a), 32'h0);
    chk("clr+load dout_b", 32'(dout_b), 32'h0);
    chk("clr+load cur_src_b", 32'(cur_src_b), 32'd1);
    chk("clr+load cur_dst_b", 32'(cur_dst_b), 32'd0);
    load = 1'b0; clr = 1'b0;
    cyc(1);
    chk("route 1->0 dout_b", 32'(dout_b), 32'h0002);
    chk("route 1->0 dout_a", 32'(dout_a), 32'h0002);
    src_sel = 2'd3; dst_sel = 2'd2; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(1);
    chk("hold dout_b", 32'(dout_b), 32'h0402);
    chk("zero dout_a", 32'(dout_a), 32'h0400);
    chk("invalid src cur_src_c", 32'(cur_src_c), 32'd1);
    chk("valid dst cur_dst_c", 32'(cur_dst_c), 32'd2);

    // Auto-scan on lane 1
    src_sel = 2'd0; dst_sel = 2'd1; load = 1'b1; scan_en = 1'b1;
    cyc(1);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      do begin
        cyc(1);
        n++;
      end while (!tick_a && n < 8);
      chk($sformatf("scan tick spacing %0d", i), 32'(n), (i == 0) ? 32'd3 : 32'd4);
      chk($sformatf("scan lane1 value %0d", i), 32'(dout_a[7:4]), 32'(exp_lane[i]));
      chk($sformatf("scan cur_src_c %0d", i), 32'(cur_src_c), 32'(exp_csc[i]));
    end

    // Load edge on the terminal-count cycle
    src_sel = 2'd2; dst_sel = 2'd1; load = 1'b1;
    #1;
    chk("collision tick suppressed", 32'(tick_a), 32'd0);
    cyc(1);
    load = 1'b0;
    chk("collision cur_src_a", 32'(cur_src_a), 32'd2);
    n = 1;
    while (!tick_a && n < 8) begin
      cyc(1);
      n++;
    end
    chk("collision next tick", 32'(n), 32'd4);

    // Manual mode, NCH=3 out-of-range source
    scan_en = 1'b0;
    cyc(3);
    src_sel = 2'd2; dst_sel = 2'd0; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(1);
    src_sel = 2'd3; dst_sel = 2'd1; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("nch3 invalid src kept", 32'(cur_src_c), 32'd2);
    chk("nch3 dst updated", 32'(cur_dst_c), 32'd1);
    chk("nch4 src 3", 32'(cur_src_a), 32'd3);
    chk("nch4 dst 1", 32'(cur_dst_a), 32'd1);
    cyc(2);

    // Reset in the middle of a scan
    scan_en = 1'b1;
    cyc(6);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-scan reset dout_b", 32'(dout_b), 32'h0);
    chk("mid-scan reset cur_src_c", 32'(cur_src_c), 32'h0);
    chk("mid-scan reset tick_a", 32'(tick_a), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    cyc(12);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
